// File: rtl/calc_pkg.sv
// Shared definitions for the calculator, its command driver and benches:
// default widths, opcode values and driver FSM state encoding.
package calc_pkg;

   localparam int CALC_W   = 16;
   localparam int CALC_OPW = 8;

   localparam logic [7:0] OP_ADD = 8'd0;
   localparam logic [7:0] OP_SUB = 8'd1;
   localparam logic [7:0] OP_MUL = 8'd2;
   localparam logic [7:0] OP_DIV = 8'd3;
   localparam logic [7:0] OP_OP4 = 8'd4;
   localparam logic [7:0] OP_OP5 = 8'd5;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;

endpackage

// File: rtl/calc_driver_if.sv
// Command and result handshakes of the calculator driver; the driver is the
// slave, the command source / result consumer is the master.
interface calc_driver_if
   import calc_pkg::*;
#(
   parameter int W   = CALC_W,
   parameter int OPW = CALC_OPW
);
   logic           cmd_valid;
   logic           cmd_ready;
   logic [W-1:0]   cmd_A;
   logic [W-1:0]   cmd_B;
   logic [W-1:0]   cmd_C;
   logic [W-1:0]   cmd_D;
   logic [OPW-1:0] cmd_opcode;
   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_data;
   logic [2:0]     res_tag;

   modport master (
      output cmd_valid, cmd_A, cmd_B, cmd_C, cmd_D, cmd_opcode, res_ready,
      input  cmd_ready, res_valid, res_data, res_tag
   );

   modport slave (
      input  cmd_valid, cmd_A, cmd_B, cmd_C, cmd_D, cmd_opcode, res_ready,
      output cmd_ready, res_valid, res_data, res_tag
   );
endinterface

// File: rtl/calc_cmd_fifo.sv
// Circular command buffer with registered pointers and occupancy count.
// Output is the current head entry; push on full and pop on empty are ignored.
module calc_cmd_fifo #(
   parameter int DW    = 72,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_r == (AW+1)'(DEPTH));
   assign empty     = (count_r == (AW+1)'(0));
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign dout      = mem_r[rd_ptr_r];

   // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end
endmodule

// File: rtl/calc_driver.sv
// Buffers calculator commands, issues them one at a time, waits the fixed
// calculator latency and presents each result with a 3-bit issue tag.
module calc_driver
   import calc_pkg::*;
#(
   parameter int W       = CALC_W,
   parameter int OPW     = CALC_OPW,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic           clk,
   input  logic           reset,
   calc_driver_if.slave   cmd_bus,
   output logic [W-1:0]   calc_A,
   output logic [W-1:0]   calc_B,
   output logic [W-1:0]   calc_C,
   output logic [W-1:0]   calc_D,
   output logic [OPW-1:0] calc_opcode,
   input  logic [W-1:0]   calc_out,
   output logic           busy
);
   localparam int DW = 4*W + OPW;
   localparam int CW = $clog2(LATENCY + 1);

   logic [1:0]    state_r;
   logic [CW-1:0] wait_cnt_r;
   logic [2:0]    issue_cnt_r;
   logic          res_valid_r;
   logic [W-1:0]  res_data_r;
   logic [2:0]    res_tag_r;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic [DW-1:0] head_s;

   assign push_s            = cmd_bus.cmd_valid && !full_s;
   assign cmd_bus.cmd_ready = !full_s;
   assign cmd_bus.res_valid = res_valid_r;
   assign cmd_bus.res_data  = res_data_r;
   assign cmd_bus.res_tag   = res_tag_r;
   assign busy              = (state_r != ST_IDLE) || !empty_s;

   calc_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({cmd_bus.cmd_A, cmd_bus.cmd_B, cmd_bus.cmd_C, cmd_bus.cmd_D, cmd_bus.cmd_opcode}),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Issue decision: from IDLE, or from RESULT on the edge the result is taken.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) pop_s = 1'b1;
            else          pop_s = 1'b0;
         end
         ST_RESULT: begin
            if (cmd_bus.res_ready && !empty_s) pop_s = 1'b1;
            else                               pop_s = 1'b0;
         end
         default: pop_s = 1'b0;
      endcase
   end

   // Issue registers, latency countdown, result capture and state sequencing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         wait_cnt_r  <= CW'(0);
         issue_cnt_r <= 3'd0;
         res_valid_r <= 1'b0;
         res_data_r  <= W'(0);
         res_tag_r   <= 3'd0;
         calc_A      <= W'(0);
         calc_B      <= W'(0);
         calc_C      <= W'(0);
         calc_D      <= W'(0);
         calc_opcode <= OPW'(0);
      end else begin
         if (pop_s) begin
            {calc_A, calc_B, calc_C, calc_D, calc_opcode} <= head_s;
            wait_cnt_r  <= CW'(LATENCY);
            res_tag_r   <= issue_cnt_r;
            issue_cnt_r <= issue_cnt_r + 3'd1;
         end
         case (state_r)
            ST_IDLE: begin
               if (pop_s) state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               // Count of 1 means calc_out now reflects the issued command.
               if (wait_cnt_r == CW'(1)) begin
                  res_data_r  <= calc_out;
                  res_valid_r <= 1'b1;
                  state_r     <= ST_RESULT;
               end else begin
                  wait_cnt_r <= wait_cnt_r - CW'(1);
               end
            end
            ST_RESULT: begin
               if (cmd_bus.res_ready) begin
                  res_valid_r <= 1'b0;
                  state_r     <= pop_s ? ST_WAIT : ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_calc_driver.sv
// Scoreboard bench for calc_driver with a two-cycle calculator stand-in whose
// output is only correct in the cycle LATENCY after its inputs change.
module tb_calc_driver;
   import calc_pkg::*;

   localparam int W       = 16;
   localparam int OPW     = 8;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   typedef struct {
      logic [W-1:0] data;
      logic [2:0]   tag;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [W-1:0]   calc_A, calc_B, calc_C, calc_D, calc_out;
   logic [OPW-1:0] calc_opcode;
   logic           busy;

   exp_t exp_q[$];
   int   hs_cyc[$];
   logic [2:0] tag_next = 3'd0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   n_res = 0;
   int   rr_mode = 0;
   logic [2:0] last_tag = 3'd0;

   calc_driver_if #(.W(W), .OPW(OPW)) bus ();

   calc_driver #(.W(W), .OPW(OPW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_bus     (bus),
      .calc_A      (calc_A),
      .calc_B      (calc_B),
      .calc_C      (calc_C),
      .calc_D      (calc_D),
      .calc_opcode (calc_opcode),
      .calc_out    (calc_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] calc_fn(logic [OPW-1:0] op, logic [W-1:0] a,
                                             logic [W-1:0] b, logic [W-1:0] c, logic [W-1:0] d);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return a * b;
         OP_DIV:  return (b == 16'd0) ? 16'hFFFF : a / b;
         OP_OP4:  return a + b + c + d;
         OP_OP5:  return a ^ b ^ c ^ d;
         default: return 16'd0;
      endcase
   endfunction

   // Calculator stand-in: result valid only in the cycle after inputs change.
   logic [W-1:0]       cm_res;
   logic               cm_chg;
   logic [4*W+OPW-1:0] cm_last;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cm_res  <= 16'd0;
         cm_chg  <= 1'b0;
         cm_last <= '0;
      end else begin
         cm_res  <= calc_fn(calc_opcode, calc_A, calc_B, calc_C, calc_D);
         cm_chg  <= ({calc_A, calc_B, calc_C, calc_D, calc_opcode} != cm_last);
         cm_last <= {calc_A, calc_B, calc_C, calc_D, calc_opcode};
      end
   end
   assign calc_out = cm_chg ? cm_res : ~cm_res;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result consumer pacing.
   initial begin
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rr_mode)
            0:       bus.res_ready = 1'b0;
            1:       bus.res_ready = 1'b1;
            default: bus.res_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares each taken result and checks held results stay stable.
   logic         hold_v = 1'b0;
   logic [W-1:0] hold_d;
   logic [2:0]   hold_t;
   always @(negedge clk) begin
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_data", 32'(bus.res_data), 32'(hold_d));
            chk("hold_tag", 32'(bus.res_tag), 32'(hold_t));
         end
         if (bus.res_valid && bus.res_ready) begin
            hold_v = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(bus.res_data), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("res_data", 32'(bus.res_data), 32'(e.data));
               chk("res_tag", 32'(bus.res_tag), 32'(e.tag));
               hs_cyc.push_back(cyc);
               last_tag = bus.res_tag;
               n_res++;
            end
         end else if (bus.res_valid) begin
            hold_v = 1'b1;
            hold_d = bus.res_data;
            hold_t = bus.res_tag;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic push_cmd(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] exp_data);
      bit done = 1'b0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_A      = a;
      bus.cmd_B      = b;
      bus.cmd_C      = c;
      bus.cmd_D      = d;
      bus.cmd_opcode = op;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            exp_q.push_back('{data: exp_data, tag: tag_next});
            tag_next = tag_next + 3'd1;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic push_rand();
      logic [OPW-1:0] op;
      logic [W-1:0] a, b, c, d;
      op = OPW'($urandom_range(0, 5));
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      push_cmd(op, a, b, c, d, calc_fn(op, a, b, c, d));
   endtask

   task automatic wait_drain(input int budget);
      int i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      tag_next = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_A = 16'd0; bus.cmd_B = 16'd0; bus.cmd_C = 16'd0; bus.cmd_D = 16'd0;
      bus.cmd_opcode = 8'd0;

      // Reset and idle state
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_res_valid", 32'(bus.res_valid), 32'd0);
      chk("idle_calc_bus", 32'(calc_A | calc_B | calc_C | calc_D), 32'd0);
      chk("idle_calc_op", 32'(calc_opcode), 32'd0);
      chk("idle_res_tag", 32'(bus.res_tag), 32'd0);
      @(posedge clk);
      #1;

      // Single ADD: calc_A appears two edges after the push
      rr_mode = 1;
      push_cmd(OP_ADD, 16'd2, 16'd2, 16'd0, 16'd0, 16'd4);
      @(negedge clk);
      chk("calc_A_not_yet", 32'(calc_A), 32'd0);
      @(negedge clk);
      chk("calc_A_issued", 32'(calc_A), 32'd2);
      @(posedge clk);
      #1;
      wait_drain(50);
      @(negedge clk);
      chk("res_valid_pulse", 32'(bus.res_valid), 32'd0);
      chk("single_count", 32'(n_res), 32'd1);
      @(posedge clk);
      #1;

      // Five commands under backpressure, then drain
      do_reset();
      rr_mode = 0;
      push_cmd(OP_SUB, 16'd10, 16'd2, 16'd0, 16'd0, 16'd8);
      push_cmd(OP_MUL, 16'd5, 16'd5, 16'd0, 16'd0, 16'd25);
      push_cmd(OP_DIV, 16'd10, 16'd2, 16'd0, 16'd0, 16'd5);
      push_cmd(OP_ADD, 16'd2, 16'd2, 16'd0, 16'd0, 16'd4);
      push_cmd(OP_ADD, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2);
      @(negedge clk);
      chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      hs_cyc.delete();
      rr_mode = 1;
      wait_drain(100);
      chk("burst_count", 32'(hs_cyc.size()), 32'd5);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("burst_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(LATENCY + 1));

      // Nine commands: tag wraps 7 -> 0
      do_reset();
      rr_mode = 1;
      n_res = 0;
      for (int i = 0; i < 9; i++) push_rand();
      wait_drain(200);
      chk("nine_count", 32'(n_res), 32'd9);
      chk("tag_wrap", 32'(last_tag), 32'd0);

      // Reset asserted while the first of a burst is waiting
      do_reset();
      rr_mode = 1;
      push_cmd(OP_ADD, 16'd7, 16'd3, 16'd0, 16'd0, 16'd10);
      push_cmd(OP_SUB, 16'd9, 16'd4, 16'd0, 16'd0, 16'd5);
      push_cmd(OP_MUL, 16'd3, 16'd3, 16'd0, 16'd0, 16'd9);
      chk("pre_reset_calc_A", 32'(calc_A), 32'd7);
      reset = 1'b1;
      exp_q.delete();
      tag_next = 3'd0;
      #1;
      chk("async_calc_A", 32'(calc_A), 32'd0);
      chk("async_res_valid", 32'(bus.res_valid), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_stale_result", 32'(bus.res_valid), 32'd0);
      end
      chk("post_reset_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Random commands against random consumer backpressure
      do_reset();
      rr_mode = 2;
      n_res = 0;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         push_rand();
      end
      wait_drain(2000);
      chk("random_count", 32'(n_res), 32'd40);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/calc_driver.md
Name: calc_driver

Overview:
- Command initiator for the calculator block; the calculator is the responder.
- Accepts operand/opcode commands on a valid/ready interface and buffers them in a small FIFO.
- Issues commands one at a time on the calculator's A/B/C/D/opcode buses and waits the calculator's fixed latency.
- Captures the calculator output and presents it with a sequence tag on a valid/ready result interface.
- Sits between any command source (bench, host sequencer) and the calculator, replacing hand-timed stimulus.

Parameters:
- W, 16: operand/result width; matches calculator A..D and out.
- OPW, 8: opcode width.
- LATENCY, 2: clock cycles from calculator inputs changing to out being valid; must be >= 1.
- DEPTH, 4: command FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_A, cmd_B, cmd_C, cmd_D  in  W each  operands.
- cmd_opcode  in  OPW  operation code.
- calc_A, calc_B, calc_C, calc_D  out  W each  registered drive to the calculator.
- calc_opcode  out  OPW  registered drive to the calculator.
- calc_out  in  W  calculator result.
- res_valid  out  1  result held for consumer.
- res_ready  in  1  consumer takes result.
- res_data  out  W  captured result.
- res_tag  out  3  issue sequence number, wraps 7->0.
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (asynchronous, active-high): FIFO emptied and pending commands discarded; state=IDLE; calc_A..D=0; calc_opcode=0; res_valid=0; res_data=0; res_tag=0; issue counter=0; busy=0; cmd_ready=1 once reset is deasserted.
- Reset mid-operation aborts at once; the in-flight result is never presented.
- Command accept: push on the rising edge when cmd_valid && cmd_ready.
  - cmd_ready = !full, combinational from FIFO count only.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle; the freed slot appears next cycle.
- FSM states: IDLE, WAIT, RESULT.
- IDLE: when the FIFO is non-empty, at the edge:
  - pop head, load calc_* registers;
  - wait counter = LATENCY;
  - res_tag = issue counter, then issue counter increments;
  - go to WAIT.
  - A command pushed in cycle t is on calc_* from t+2 at the earliest, because the FIFO write precedes the read.
- WAIT: the counter decrements each cycle. When counter==1, at the edge: res_data<=calc_out, res_valid<=1, go to RESULT. calc_out is therefore sampled exactly LATENCY cycles after calc_* changed.
- RESULT: res_valid, res_data and res_tag are held stable until res_ready.
  - On the edge with res_ready=1: res_valid<=0.
  - If the FIFO is non-empty, pop and load in the same edge, go to WAIT (back-to-back).
  - Otherwise go to IDLE.
- Throughput: one command per LATENCY+1 cycles with res_ready tied high.
- calc_* hold their last issued values while in IDLE, WAIT and RESULT; they change only on a pop.
- Backpressure: res_ready low stalls issue. The FIFO keeps accepting until full, then cmd_ready drops. No result is ever dropped or overwritten.
- FIFO: circular read/write pointers of log2(DEPTH) bits, wrapping DEPTH-1->0; count of log2(DEPTH)+1 bits.
  - A simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
  - A pop on empty never occurs, because the FSM checks empty.
- Tag wraps 7->0 on the 9th issue.
- Result width is W; the driver does no arithmetic and passes calc_out through unmodified.

Decomposition:
- Package calc_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_OP4=4, OP_OP5=5;
  - FSM state encoding;
  - default W/OPW.
- Shared with the calculator and the bench.
- One sub-module: calc_cmd_fifo (DEPTH x (4W+OPW), registered pointers, full/empty flags, asynchronous active-high reset).
- The FSM, wait counter, tag counter and output registers stay in calc_driver.

Test Plan:
- Reset held, then released with no commands -> cmd_ready=1, busy=0, res_valid=0, calc_*=0 indefinitely.
- Single command A=2,B=2,opcode=OP_ADD, calculator model returning 4 after LATENCY=2, res_ready=1 -> calc_A=2 two cycles after push; res_valid pulses one cycle with res_data=4, res_tag=0.
- Five commands pushed back-to-back (10-2 SUB, 5*5 MUL, 10/2 DIV, 2+2 ADD, 1+1 ADD) with res_ready=0 -> cmd_ready drops after the FIFO fills (one command already issued, four queued). Then res_ready=1 yields results 8, 25, 5, 4, 2 in order with tags 0..4 and spacing LATENCY+1.
- Nine sequential commands -> res_tag sequence 0..7 then 0.
- Reset asserted during WAIT of a queued burst -> outputs return to reset values asynchronously; after release no stale result appears and busy=0.
- res_ready toggled randomly against a reference queue model -> every result appears exactly once, in order, with res_data stable while res_valid=1 && !res_ready.
